// File: rtl/dcache_axi_master_pkg.sv
// Shared constants for the L1 data-cache AXI4 master: AXI encodings,
// cache access-size codes, FSM state encoding and the uncacheable tag.
package dcache_axi_master_pkg;

  // AXI4 field encodings used by this master.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  // Defaults for the top-level parameters.
  localparam logic [3:0]  AXI_ID_DEFAULT      = 4'd1;
  localparam logic [21:0] UNCACHE_TAG_DEFAULT = 22'h040000;

  // Access size codes presented by the cache on D_type.
  localparam logic [2:0] CACHE_BYTE    = 3'b000;
  localparam logic [2:0] CACHE_HWORD   = 3'b001;
  localparam logic [2:0] CACHE_WORD    = 3'b010;
  localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
  localparam logic [2:0] CACHE_HWORD_U = 3'b101;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_ADDR = 3'd1;
  localparam state_t ST_RD_DATA = 3'd2;
  localparam state_t ST_WR_ADDR = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane alignment for single-beat stores: turns access size, byte offset
// and LSB-aligned store data into AXI WSTRB/WDATA.
module axi_wstrb_gen
  import dcache_axi_master_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  // Strobe from access size; the 4-bit shift deliberately truncates a
  // halfword at offset 3 down to the top lane only.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    wstrb_o = 4'b1111;
    case (type_i)
      CACHE_BYTE, CACHE_BYTE_U:   wstrb_o = 4'b0001 << offset_i;
      CACHE_HWORD, CACHE_HWORD_U: wstrb_o = 4'b0011 << offset_i;
      CACHE_WORD:                 wstrb_o = 4'b1111;
      default:                    wstrb_o = 4'b1111;
    endcase
  end

  // Move the LSB-aligned store data onto the addressed byte lanes.
  assign wdata_o = data_i << {offset_i, 3'b000};

endmodule

// File: rtl/dcache_axi_master.sv
// Memory-side AXI4 master behind the L1 data cache. One transaction at a
// time: cacheable read misses become INCR line fills, uncacheable reads a
// single beat, and write-through stores a single strobed write beat.
module dcache_axi_master
  import dcache_axi_master_pkg::*;
#(
  parameter logic [3:0]  AXI_ID      = AXI_ID_DEFAULT,
  parameter logic [21:0] UNCACHE_TAG = UNCACHE_TAG_DEFAULT,
  parameter int          LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  // cache side
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_write,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        D_wait,
  // read address channel
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  // read data channel
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  // write address channel
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // write data channel
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // write response channel
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  // sticky error flag
  output logic        bus_err
);

  localparam int         CNT_W    = $clog2(LINE_WORDS);
  localparam logic [3:0] FILL_LEN = 4'(LINE_WORDS - 1);

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       type_q, type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             bus_err_q, bus_err_d;

  logic             uncached;
  logic [3:0]       rd_len;
  logic             rd_beat;
  logic             wr_cpl;
  logic             aw_now;
  logic             w_now;

  // Read shape is decided by the latched address's region.
  assign uncached = (addr_q[31:10] == UNCACHE_TAG);
  assign rd_len   = uncached ? 4'd0 : FILL_LEN;

  assign rd_beat  = (state_q == ST_RD_DATA) && RVALID;
  assign wr_cpl   = (state_q == ST_WR_RESP) && BVALID;

  // Write-address channel acceptance, counting a handshake seen this cycle.
  assign aw_now   = aw_done_q || AWREADY;
  assign w_now    = w_done_q || WREADY;

  // Cache side: read beats pass straight through in their RVALID cycle.
  assign D_wait   = !(rd_beat || wr_cpl);
  assign D_out    = rd_beat ? RDATA : 32'h0;
  assign bus_err  = bus_err_q;

  // AR channel, driven from the latched request so it stays stable.
  assign ARID     = AXI_ID;
  assign ARADDR   = uncached ? {addr_q[31:2], 2'b00} : {addr_q[31:4], 4'b0000};
  assign ARLEN    = rd_len;
  assign ARSIZE   = AXI_SIZE_WORD;
  assign ARBURST  = AXI_BURST_INCR;
  assign ARVALID  = (state_q == ST_RD_ADDR);
  assign RREADY   = (state_q == ST_RD_DATA);

  // AW/W channels: both raised on entry, each dropped after its own handshake.
  assign AWID     = AXI_ID;
  assign AWADDR   = addr_q;
  assign AWLEN    = 4'd0;
  assign AWSIZE   = AXI_SIZE_WORD;
  assign AWBURST  = AXI_BURST_INCR;
  assign AWVALID  = (state_q == ST_WR_ADDR) && !aw_done_q;
  assign WVALID   = (state_q == ST_WR_ADDR) && !w_done_q;
  assign WLAST    = 1'b1;
  assign BREADY   = (state_q == ST_WR_RESP);

  axi_wstrb_gen u_wstrb_gen (
    .type_i   (type_q),
    .offset_i (addr_q[1:0]),
    .data_i   (data_q),
    .wstrb_o  (WSTRB),
    .wdata_o  (WDATA)
  );

  // Next-state logic: request capture, channel sequencing, error recording.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bus_err_d = bus_err_q;

    case (state_q)
      ST_IDLE: begin
        if (D_req) begin
          addr_d    = D_addr;
          data_d    = D_in;
          type_d    = D_type;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = D_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (ARREADY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (RVALID) begin
          cnt_d = cnt_q + 1'b1;
          if (RRESP != AXI_RESP_OKAY) bus_err_d = 1'b1;
          if (RLAST) begin
            if (4'(cnt_q) != rd_len) bus_err_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WR_ADDR: begin
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (BVALID) begin
          if (BRESP != AXI_RESP_OKAY) bus_err_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      // NOTE: the latched request datapath is reset too, so ARADDR/AWADDR and
      // the strobe outputs never show X after reset.
      addr_q    <= '0;
      data_q    <= '0;
      type_q    <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Directed bench for dcache_axi_master. Stimulus tasks push expected AR, AW,
// W and completion records into queues; a negedge monitor pops and compares
// whenever the DUT handshakes on a channel or drops D_wait.
module tb_dcache_axi_master;
  import dcache_axi_master_pkg::*;

  logic        clk, rst;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in, D_out;
  logic [2:0]  D_type;
  logic        D_wait;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN, WSTRB;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        bus_err;

  dcache_axi_master dut (
    .clk(clk), .rst(rst),
    .D_req(D_req), .D_addr(D_addr), .D_write(D_write), .D_in(D_in),
    .D_type(D_type), .D_out(D_out), .D_wait(D_wait),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic is_wr; logic [31:0] data; } cpl_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] len; } addr_t;
  typedef struct packed { logic [3:0] strb; logic [31:0] data; } wbeat_t;

  cpl_t   cpl_q[$];
  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];

  cpl_t   mon_c;
  addr_t  mon_a;
  wbeat_t mon_w;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every DUT-presented output against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (!D_wait) begin
        if (cpl_q.size() == 0) begin
          check("spurious_dwait", {31'b0, D_wait}, 32'd1);
        end else begin
          mon_c = cpl_q.pop_front();
          if (mon_c.is_wr) begin
            check("wr_cpl_dout", D_out, mon_c.data);
            check("wr_cpl_in_bvalid", {31'b0, BVALID}, 32'd1);
          end else begin
            check("rd_beat_dout", D_out, mon_c.data);
            check("rd_beat_in_rvalid", {31'b0, RVALID}, 32'd1);
          end
        end
      end
      if (ARVALID && ARREADY) begin
        if (ar_q.size() == 0) begin
          check("spurious_ar", {31'b0, ARVALID}, 32'd0);
        end else begin
          mon_a = ar_q.pop_front();
          check("araddr", ARADDR, mon_a.addr);
          check("arlen", {28'b0, ARLEN}, {28'b0, mon_a.len});
          check("arsize_burst_id", {23'b0, ARSIZE, ARBURST, ARID},
                {23'b0, 3'b010, 2'b01, 4'd1});
        end
      end
      if (AWVALID && AWREADY) begin
        if (aw_q.size() == 0) begin
          check("spurious_aw", {31'b0, AWVALID}, 32'd0);
        end else begin
          mon_a = aw_q.pop_front();
          check("awaddr", AWADDR, mon_a.addr);
          check("awlen_size_burst_id", {19'b0, AWLEN, AWSIZE, AWBURST, AWID},
                {19'b0, 4'd0, 3'b010, 2'b01, 4'd1});
        end
      end
      if (WVALID && WREADY) begin
        if (w_q.size() == 0) begin
          check("spurious_w", {31'b0, WVALID}, 32'd0);
        end else begin
          mon_w = w_q.pop_front();
          check("wstrb", {28'b0, WSTRB}, {28'b0, mon_w.strb});
          check("wdata", WDATA, mon_w.data);
          check("wlast", {31'b0, WLAST}, 32'd1);
        end
      end
    end
  end

  // Present one request for a single cycle, then scramble the request bus.
  task automatic issue(input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input logic [2:0] typ);
    @(posedge clk); #1;
    D_req = 1'b1; D_addr = addr; D_write = wr; D_in = data; D_type = typ;
    @(posedge clk); #1;
    D_req = 1'b0; D_addr = 32'hDEAD_BEEF; D_write = ~wr; D_in = 32'hFFFF_FFFF;
    D_type = CACHE_WORD;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_ar,
                         input logic [3:0] exp_len, input int stall,
                         input int nbeats, input logic [31:0] base,
                         input int err_beat);
    ar_q.push_back('{addr: exp_ar, len: exp_len});
    for (int b = 0; b < nbeats; b++) cpl_q.push_back('{is_wr: 1'b0, data: base + b});
    issue(addr, 1'b0, 32'h0, CACHE_WORD);
    for (int s = 0; s < stall; s++) begin
      check("ar_stall_valid", {31'b0, ARVALID}, 32'd1);
      check("ar_stall_addr", ARADDR, exp_ar);
      @(posedge clk); #1;
    end
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      RVALID = 1'b1; RDATA = base + b; RLAST = (b == nbeats - 1);
      RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
      @(posedge clk); #1;
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] typ, input logic [3:0] exp_strb,
                          input logic [31:0] exp_data, input int aw_dly,
                          input int w_dly, input int b_dly);
    int last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    aw_q.push_back('{addr: addr, len: 4'd0});
    w_q.push_back('{strb: exp_strb, data: exp_data});
    cpl_q.push_back('{is_wr: 1'b1, data: 32'h0});
    issue(addr, 1'b1, data, typ);
    for (int c = 0; c <= last; c++) begin
      AWREADY = (c == aw_dly);
      WREADY  = (c == w_dly);
      @(posedge clk); #1;
    end
    AWREADY = 1'b0; WREADY = 1'b0;
    check("wr_valids_dropped", {30'b0, AWVALID, WVALID}, 32'd0);
    check("wr_bready", {31'b0, BREADY}, 32'd1);
    for (int c = 0; c < b_dly; c++) begin
      @(posedge clk); #1;
    end
    BVALID = 1'b1; BRESP = 2'b00;
    @(posedge clk); #1;
    BVALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    D_req = 1'b0; D_addr = '0; D_write = 1'b0; D_in = '0; D_type = CACHE_WORD;
    ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    #12;
    check("rst_valids", {27'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
    check("rst_dwait", {31'b0, D_wait}, 32'd1);
    check("rst_dout", D_out, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cacheable fill, zero-wait slave.
    do_read(32'h0000_1238, 32'h0000_1230, 4'd3, 0, 4, 32'h0000_00A0, -1);
    // Uncacheable single beat.
    do_read(32'h1000_0004, 32'h1000_0004, 4'd0, 0, 1, 32'hC0FF_EE00, -1);
    // Stores: byte at offset 3, halfword with AW late, word with W late,
    // misaligned halfword truncation, unsigned byte variant.
    do_write(32'h0000_0103, 32'h0000_005A, CACHE_BYTE,    4'b1000, 32'h5A00_0000, 0, 0, 0);
    do_write(32'h0000_0206, 32'h0000_BEEF, CACHE_HWORD,   4'b1100, 32'hBEEF_0000, 2, 0, 1);
    do_write(32'h0000_0300, 32'h1234_5678, CACHE_WORD,    4'b1111, 32'h1234_5678, 0, 2, 0);
    do_write(32'h0000_0407, 32'h0000_BEEF, CACHE_HWORD_U, 4'b1000, 32'hEF00_0000, 1, 1, 0);
    do_write(32'h0000_0501, 32'h0000_0077, CACHE_BYTE_U,  4'b0010, 32'h0000_7700, 0, 0, 0);
    // D_req already dropped; ARREADY stalled five cycles.
    do_read(32'h0000_5004, 32'h0000_5000, 4'd3, 5, 4, 32'h0000_0050, -1);
    check("no_err_yet", {31'b0, bus_err}, 32'd0);

    // SLVERR on beat 2: data still delivered, error becomes sticky.
    do_read(32'h0000_6008, 32'h0000_6000, 4'd3, 0, 4, 32'h0000_00E0, 2);
    check("slverr_sticky", {31'b0, bus_err}, 32'd1);

    // Second fill aborted by reset after two beats.
    ar_q.push_back('{addr: 32'h0000_7000, len: 4'd3});
    cpl_q.push_back('{is_wr: 1'b0, data: 32'h0000_0070});
    cpl_q.push_back('{is_wr: 1'b0, data: 32'h0000_0071});
    issue(32'h0000_7000, 1'b0, 32'h0, CACHE_WORD);
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    for (int b = 0; b < 2; b++) begin
      RVALID = 1'b1; RDATA = 32'h0000_0070 + b; RLAST = 1'b0;
      @(posedge clk); #1;
    end
    check("err_before_rst", {31'b0, bus_err}, 32'd1);
    RVALID = 1'b1; RDATA = 32'h0000_0072;
    rst = 1'b1;
    #1;
    check("midrst_valids", {27'b0, ARVALID, AWVALID, WVALID, RREADY, BREADY}, 32'd0);
    check("midrst_dwait", {31'b0, D_wait}, 32'd1);
    check("midrst_bus_err", {31'b0, bus_err}, 32'd0);
    RVALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill whose RLAST arrives on beat 3 of 4: count mismatch flags an error.
    do_read(32'h0000_8000, 32'h0000_8000, 4'd3, 0, 3, 32'h0000_0080, -1);
    check("rlast_mismatch_err", {31'b0, bus_err}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("cpl_q_drained", cpl_q.size(), 32'd0);
    check("ar_q_drained", ar_q.size(), 32'd0);
    check("aw_w_q_drained", aw_q.size() + w_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
